// File: rtl/fb_fill_rect_pkg.sv
// Shared draw-engine package: FSM state type, default coordinate width and
// signed min/max helpers reused by the rect, line and circle engines.
package draw_pkg;

    localparam int CORDW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } draw_state_t;

    // Coordinates are widened to 32 bits for ordering/clamping so the helpers
    // serve any engine regardless of its CORDW.
    typedef logic signed [31:0] coord_wide_t;

    function automatic coord_wide_t smin(coord_wide_t a, coord_wide_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_wide_t smax(coord_wide_t a, coord_wide_t b);
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/fb_fill_rect_if.sv
// Command/pixel bus between a scene sequencer (master) and the rectangle
// fill engine (slave); pixel outputs feed the framebuffer write port.
interface fb_fill_rect_if
    import draw_pkg::*;
#(
    parameter int CORDW = CORDW_DEF
);
    logic                    start;
    logic                    oe;
    logic signed [CORDW-1:0] x0;
    logic signed [CORDW-1:0] y0;
    logic signed [CORDW-1:0] x1;
    logic signed [CORDW-1:0] y1;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    drawing;
    logic                    busy;
    logic                    done;

    modport master (
        output start, oe, x0, y0, x1, y1,
        input  x, y, drawing, busy, done
    );

    modport slave (
        input  start, oe, x0, y0, x1, y1,
        output x, y, drawing, busy, done
    );
endinterface

// File: rtl/fb_fill_rect.sv
// Filled-rectangle engine: one raster-order pixel per oe cycle, first pixel two
// cycles after start; oe low stalls in place. FB_FILL_RECT_CLIP_EN clamps to WIDTHxHEIGHT.
module fb_fill_rect
    import draw_pkg::*;
#(
    parameter int CORDW  = CORDW_DEF,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic          clk,
    input  logic          rst,
    fb_fill_rect_if.slave bus
);

    draw_state_t state_q, state_d;

    logic signed [CORDW-1:0] x0_q, x0_d, y0_q, y0_d;
    logic signed [CORDW-1:0] x1_q, x1_d, y1_q, y1_d;
    logic signed [CORDW-1:0] xa_q, xa_d, xb_q, xb_d, yb_q, yb_d;
    logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    coord_wide_t ord_xa, ord_xb, ord_ya, ord_yb;
    logic        rect_empty;
    logic        last_px;

    // Degenerate geometry makes the clip window meaningless; nothing to build.
    if (WIDTH <= 0 || HEIGHT <= 0) begin : g_bad_geometry
    end

`ifdef FB_FILL_RECT_CLIP_EN
    localparam coord_wide_t X_MAX = coord_wide_t'(WIDTH - 1);
    localparam coord_wide_t Y_MAX = coord_wide_t'(HEIGHT - 1);
`endif

    // Corner ordering (and optional clamp) works on the captured corners.
    always_comb begin
        ord_xa     = smin(coord_wide_t'(x0_q), coord_wide_t'(x1_q));
        ord_xb     = smax(coord_wide_t'(x0_q), coord_wide_t'(x1_q));
        ord_ya     = smin(coord_wide_t'(y0_q), coord_wide_t'(y1_q));
        ord_yb     = smax(coord_wide_t'(y0_q), coord_wide_t'(y1_q));
        rect_empty = 1'b0;
`ifdef FB_FILL_RECT_CLIP_EN
        ord_xa     = smax(ord_xa, '0);
        ord_ya     = smax(ord_ya, '0);
        ord_xb     = smin(ord_xb, X_MAX);
        ord_yb     = smin(ord_yb, Y_MAX);
        rect_empty = (ord_xa > ord_xb) || (ord_ya > ord_yb);
`endif
    end

    assign last_px = (x_q == xb_q) && (y_q == yb_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = INIT;
            INIT:    state_d = rect_empty ? DONE : DRAW;
            DRAW:    if (bus.oe && last_px) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x0_d   = x0_q;
        y0_d   = y0_q;
        x1_d   = x1_q;
        y1_d   = y1_q;
        xa_d   = xa_q;
        xb_d   = xb_q;
        yb_d   = yb_q;
        x_d    = x_q;
        y_d    = y_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d   = bus.x0;
                    y0_d   = bus.y0;
                    x1_d   = bus.x1;
                    y1_d   = bus.y1;
                    busy_d = 1'b1;
                end
            end
            INIT: begin
                xa_d = CORDW'(ord_xa);
                xb_d = CORDW'(ord_xb);
                yb_d = CORDW'(ord_yb);
                if (rect_empty) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    x_d = CORDW'(ord_xa);
                    y_d = CORDW'(ord_ya);
                end
            end
            DRAW: begin
                if (bus.oe) begin
                    if (x_q < xb_q) begin
                        x_d = x_q + CORDW'(1);
                    end else if (y_q < yb_q) begin
                        x_d = xa_q;
                        y_d = y_q + CORDW'(1);
                    end else begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q   <= '0;
            y0_q   <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            xa_q   <= '0;
            xb_q   <= '0;
            yb_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x0_q   <= x0_d;
            y0_q   <= y0_d;
            x1_q   <= x1_d;
            y1_q   <= y1_d;
            xa_q   <= xa_d;
            xb_q   <= xb_d;
            yb_q   <= yb_d;
            x_q    <= x_d;
            y_q    <= y_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.drawing = (state_q == DRAW) && bus.oe;

    a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
        done_q |-> !busy_q);
    a_done_single   : assert property (@(posedge clk) disable iff (rst)
        done_q |=> !done_q);
    a_draw_in_cmd   : assert property (@(posedge clk) disable iff (rst)
        bus.drawing |-> busy_q);

endmodule

// File: tb/tb_fb_fill_rect.sv
// Scoreboard bench for fb_fill_rect: directed commands push hand-computed
// expected events (pixel, done, state snapshot) that a monitor checks per cycle.
module tb_fb_fill_rect;
    import draw_pkg::*;

    localparam int CW     = 16;
    localparam int K_PIX  = 0;
    localparam int K_DONE = 1;
    localparam int K_ST   = 2;

    typedef struct {
        int kind;
        int cyc;
        int x;
        int y;
        int busy;
        int drw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    fb_fill_rect_if #(.CORDW(CW)) bus ();

    fb_fill_rect #(.CORDW(CW), .WIDTH(160), .HEIGHT(120)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int c, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, c, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int px, input int py,
                        input int b, input int d);
        exp_t e;
        e.kind = kind; e.cyc = c; e.x = px; e.y = py; e.busy = b; e.drw = d;
        sb.push_back(e);
    endtask

    // Monitor: samples 2 ns after the falling edge, when the driver has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_event kind=%0d expected_cycle=%0d now=%0d", e.kind, e.cyc, cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                case (e.kind)
                    K_PIX: begin
                        chk("pix_drawing", cyc, bus.drawing, 1);
                        chk("pix_busy",    cyc, bus.busy, 1);
                        chk("pix_x",       cyc, bus.x, e.x);
                        chk("pix_y",       cyc, bus.y, e.y);
                    end
                    K_DONE: begin
                        chk("done_pulse",   cyc, bus.done, 1);
                        chk("done_busy",    cyc, bus.busy, 0);
                        chk("done_drawing", cyc, bus.drawing, 0);
                        chk("done_x",       cyc, bus.x, e.x);
                        chk("done_y",       cyc, bus.y, e.y);
                    end
                    default: begin
                        chk("st_busy",    cyc, bus.busy, e.busy);
                        chk("st_drawing", cyc, bus.drawing, e.drw);
                        chk("st_done",    cyc, bus.done, 0);
                        chk("st_x",       cyc, bus.x, e.x);
                        chk("st_y",       cyc, bus.y, e.y);
                    end
                endcase
            end else if (bus.drawing === 1'b1 || bus.done === 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output cycle=%0d drawing=%0b done=%0b x=%0d y=%0d expected=none",
                         cyc, bus.drawing, bus.done, bus.x, bus.y);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic issue(input int ax, input int ay, input int bx, input int by, output int t);
        @(negedge clk);
        t         = cyc;
        bus.x0    = CW'(ax);
        bus.y0    = CW'(ay);
        bus.x1    = CW'(bx);
        bus.y1    = CW'(by);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Expected pixels of (2,3)-(4,4) in raster order, as x,y pairs.
    int px6[12] = '{2,3, 3,3, 4,3, 2,4, 3,4, 4,4};

    task automatic scen_rect(input int ax, input int ay, input int bx, input int by,
                             input int px, input int py);
        int t;
        issue(ax, ay, bx, by, t);
        push(K_ST, t + 1, px, py, 1, 0);
        for (int i = 0; i < 6; i++) push(K_PIX, t + 2 + i, px6[2*i], px6[2*i+1], 1, 1);
        push(K_DONE, t + 8, 4, 4, 0, 0);
        drain();
    endtask

    initial begin
        int t;
        bus.start = 1'b0;
        bus.oe    = 1'b1;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        repeat (2) @(negedge clk);
        push(K_ST, cyc, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        scen_rect(2, 3, 4, 4, 0, 0);
        scen_rect(4, 4, 2, 3, 4, 4);

        // oe toggles 1,0 from T+2: pixels on even offsets, holds on odd ones.
        issue(2, 3, 4, 4, t);
        push(K_ST, t + 1, 4, 4, 1, 0);
        for (int i = 0; i < 6; i++) begin
            push(K_PIX, t + 2 + 2*i, px6[2*i], px6[2*i+1], 1, 1);
            if (i == 0) push(K_ST, t + 3, 3, 3, 1, 0);
            if (i == 3) push(K_ST, t + 9, 3, 4, 1, 0);
        end
        push(K_DONE, t + 13, 4, 4, 0, 0);
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            bus.oe = (k % 2 == 0);
        end
        @(negedge clk);
        bus.oe = 1'b1;
        drain();

        // Single pixel; a start pulse during INIT must be ignored.
        issue(5, 5, 5, 5, t);
        push(K_ST, t + 1, 4, 4, 1, 0);
        push(K_PIX, t + 2, 5, 5, 1, 1);
        push(K_DONE, t + 3, 5, 5, 0, 0);
        push(K_ST, t + 5, 5, 5, 0, 0);
        bus.x0 = '0; bus.y0 = '0; bus.x1 = CW'(1); bus.y1 = CW'(1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Reset during the 4th pixel of a 10x10 fill.
        issue(0, 0, 9, 9, t);
        push(K_ST, t + 1, 5, 5, 1, 0);
        for (int i = 0; i < 4; i++) push(K_PIX, t + 2 + i, i, 0, 1, 1);
        push(K_ST, t + 6, 0, 0, 0, 0);
        push(K_ST, t + 7, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drain();

        scen_rect(2, 3, 4, 4, 0, 0);

`ifdef FB_FILL_RECT_CLIP_EN
        issue(-2, -2, 1, 1, t);
        push(K_PIX, t + 2, 0, 0, 1, 1);
        push(K_PIX, t + 3, 1, 0, 1, 1);
        push(K_PIX, t + 4, 0, 1, 1, 1);
        push(K_PIX, t + 5, 1, 1, 1, 1);
        push(K_DONE, t + 6, 1, 1, 0, 0);
        drain();
        issue(200, 0, 210, 5, t);
        push(K_ST, t + 1, 1, 1, 1, 0);
        push(K_DONE, t + 2, 1, 1, 0, 0);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fb_fill_rect.md
Name: fb_fill_rect

Overview:
- Drawing engine on the write side of the indexed-colour framebuffer.
- Takes two corner coordinates and generates one pixel coordinate per enabled cycle, covering a filled rectangle.
- Outputs drive the framebuffer write port directly: x, y and drawing (as write enable); colour index is supplied externally.
- Start/busy/done handshake lets a higher-level scene sequencer chain draw commands.

Parameters:
CORDW, 16, signed coordinate width (bits)
WIDTH, 160, framebuffer width in pixels (used only with clip feature)
HEIGHT, 120, framebuffer height in pixels (used only with clip feature)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset is synchronous and active-high
start  input  1  begin drawing; sampled only in IDLE
oe  input  1  output enable; low stalls drawing (coordinates hold)
x0  input  CORDW  corner A x, signed
y0  input  CORDW  corner A y, signed
x1  input  CORDW  corner B x, signed
y1  input  CORDW  corner B y, signed
x  output  CORDW  current pixel x, signed
y  output  CORDW  current pixel y, signed
drawing  output  1  (x,y) is a valid pixel this cycle
busy  output  1  command in progress
done  output  1  one-cycle pulse: command complete

Behaviour:
- FSM states: IDLE, INIT, DRAW, DONE.
- Reset values: state IDLE; x=0, y=0, busy=0, done=0. drawing=0 (follows from state).
- Reset overrides every state. Reset mid-command: IDLE next cycle, no done pulse, captured corners discarded.
- IDLE:
  - start=1 at cycle T: register x0,y0,x1,y1; go INIT; busy=1 from T+1.
  - start while busy, or in the DONE cycle: ignored.
- INIT (one cycle):
  - Order corners: xa=min(x0,x1), xb=max(x0,x1), ya=min(y0,y1), yb=max(y0,y1).
  - All comparisons signed, CORDW bits.
  - Load x<=xa, y<=ya; go DRAW.
- DRAW:
  - drawing = (state==DRAW) && oe, combinational; all other outputs registered.
  - oe=1: current (x,y) is emitted, then advance:
    - x<xb: x<=x+1.
    - x==xb and y<yb: x<=xa, y<=y+1.
    - x==xb and y==yb: go DONE.
  - oe=0: x, y and state hold.
- DONE:
  - done=1 and busy=0 for exactly this cycle; next state IDLE.
  - x, y retain the last pixel.
- Timing:
  - With oe held high, first drawing cycle is T+2.
  - Pixel count is (xb-xa+1)*(yb-ya+1), raster order (row-major, increasing x then y).
  - done asserts the cycle after the last drawing cycle.
- Degenerate single pixel (x0==x1, y0==y1): exactly one drawing cycle.
- No internal clipping by default. Negative or out-of-range coordinates are emitted unchanged; the framebuffer's clip logic discards them.
- Arithmetic: x+1 and y+1 are CORDW-bit signed. The caller guarantees xb, yb < 2^(CORDW-1)-1, so no wrap.

Optional Feature:
- Macro: FB_FILL_RECT_CLIP_EN.
- Defined: INIT clamps the ordered corners to the framebuffer:
  - xa=max(xa,0), ya=max(ya,0), xb=min(xb,WIDTH-1), yb=min(yb,HEIGHT-1).
  - If xa>xb or ya>yb after clamping, INIT goes directly to DONE: zero drawing cycles, done still pulses.
  - INIT stays one cycle.
- Undefined: no clamping; WIDTH and HEIGHT are unused.

Decomposition:
- Shared draw package (draw_pkg):
  - State enum type for the draw FSM, reused by sibling line/circle engines.
  - Default CORDW constant.
- No sub-module required. The min/max corner ordering is a small in-module function shared via the package.

Test Plan:
1. start with (2,3)-(4,4), oe=1 -> drawing for 6 cycles from T+2: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4); done at T+8; busy high T+1..T+7.
2. start with (4,4)-(2,3), oe=1 -> identical sequence and timing to scenario 1.
3. Scenario 1 with oe alternating 1,0 from T+2 -> same 6 pixels in order; x,y hold during oe=0; done at T+13.
4. start with (5,5)-(5,5) -> one drawing cycle at (5,5) at T+2; done at T+3; start pulsed at T+1 is ignored.
5. Reset at the 4th drawing cycle of a (0,0)-(9,9) fill -> next cycle busy=0, drawing=0, x=y=0; no done pulse; a fresh start works normally.
6. FB_FILL_RECT_CLIP_EN, WIDTH=160, HEIGHT=120:
   - (-2,-2)-(1,1) -> 4 pixels (0,0),(1,0),(0,1),(1,1).
   - (200,0)-(210,5) -> DONE reached at T+2, zero drawing cycles.
